stereo_config_sequencer: RTL and testbench
==========================================

# stereo_config_sequencer

Sequences SCCB register configuration of the left and right OV7670 cameras so that only one controller is configuring at a time. It handles power-up settling, per-camera completion timeouts, bounded retry, and a user-requested reconfigure. It sits between the debounced centre-button pulse and the `resend` inputs of the two `ov7670_controller` instances, all in the `clk_camera` domain. It reports status for LEDs and for downstream capture gating.

## Interface
- `PWRUP_CYCLES`, default 5_000_000: settle time after reset before the first configuration (100 ms at 50 MHz).
- `RESEND_CYCLES`, default 4: width of each `resend_*` pulse, ≥1.
- `TIMEOUT_CYCLES`, default 2_500_000: limit for each wait phase (finished-low, finished-high).
- `MAX_RETRY`, default 3: retries per camera before error, ≥0.
- `clk` in 1: camera clock, 50 MHz; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle reconfigure request (debounced button).
- `fin_l` in 1: left controller `config_finished`, same clock domain, level.
- `fin_r` in 1: right controller `config_finished`, same clock domain, level.
- `resend_l` out 1: restart left controller configuration; high for `RESEND_CYCLES`.
- `resend_r` out 1: restart right controller configuration; high for `RESEND_CYCLES`.
- `busy` out 1: sequence in progress.
- `done` out 1: both cameras configured; stays high until the next sequence starts.
- `error` out 1: a camera exhausted its retries; stays high until the next `start` or reset.
- `err_cam` out 1: camera that failed (0 = left, 1 = right); valid while `error` is high.
- `retries` out 2: retry count of the current camera, saturating at 3.

## Operation
- States: PWRUP, IDLE, PULSE_L, LOW_L, HIGH_L, PULSE_R, LOW_R, HIGH_R, DONE, ERROR.
- PWRUP is entered on reset. It waits `PWRUP_CYCLES`, then goes to PULSE_L. `start` is ignored in PWRUP.
- IDLE is unused after power-up. `start` from DONE or ERROR goes to PULSE_L, clears `done`, `error` and `retries`, and skips PWRUP.
- PULSE_x drives `resend_x` high for exactly `RESEND_CYCLES`, then goes to LOW_x.
- LOW_x waits for `fin_x` = 0, then goes to HIGH_x.
- HIGH_x waits for `fin_x` = 1.
  - Left: goes to PULSE_R with `retries` cleared.
  - Right: goes to DONE.
- Timeout: if `TIMEOUT_CYCLES` elapse in LOW_x or HIGH_x, the block increments `retries`.
  - If the retry count was below `MAX_RETRY`, it re-enters PULSE_x.
  - Otherwise it goes to ERROR with `err_cam` = x.
- `start` during any busy state is ignored; it is not queued.
- `resend_l` and `resend_r` are never high in the same cycle.
- The timer counter is sized by `$clog2` of the maximum of the three cycle parameters.
- `retries` saturates; it never wraps.

## Timing
- Reset values: `resend_l`=0, `resend_r`=0, `busy`=0, `done`=0, `error`=0, `err_cam`=0, `retries`=0. Timer is loaded with `PWRUP_CYCLES`.
- All outputs are registered.
- `busy` is high from the first clock after reset release until the cycle DONE or ERROR is entered.
- `start` sampled high in DONE or ERROR → `resend_l` high on the next edge; `busy` high the same edge.
- The timer loads on state entry. The timeout fires on the edge at which `TIMEOUT_CYCLES` cycles have been spent in the state.
- If a `fin_x` transition and the timeout land in the same cycle, the `fin_x` transition wins.
- An `rst_n` assertion mid-sequence immediately drops `resend_*` and returns to PWRUP.

## Structure
- Shared package `stereocam_pkg`:
  - state enum `cfg_state_t`;
  - `CAM_LEFT` and `CAM_RIGHT` constants;
  - default timing constants for a 50 MHz camera clock.
- Sub-module `cycle_timer`: loadable down-counter with `load`, `value` and `expired`. It is instantiated once and shared across states.
- The main module holds only the FSM, the retry counter and the output registers.

## Test plan
Scenario parameters: PWRUP=10, RESEND=2, TIMEOUT=20, MAX_RETRY=2.

- **Nominal power-up:** release reset; controller model drops `fin` 3 cycles after `resend` and raises it 8 cycles later. Required: `resend_l` high for 2 cycles starting 10 cycles after reset release; `resend_r` follows only after `fin_l` rises; `done`=1, `busy`=0, `retries`=0.
- **Left retry:** `fin_l` stuck high for the first attempt, nominal afterwards. Required: `resend_l` re-pulses 20 cycles after entering LOW_L; `retries`=1 during the second attempt; it clears to 0 when PULSE_R starts; `done`=1.
- **Right failure:** `fin_r` stuck low after `resend_r`. Required: 3 `resend_r` pulses total; then `error`=1, `err_cam`=1, `retries`=2, `busy`=0, `done`=0.
- **Start handling:** `start` pulsed during HIGH_L, then again in DONE. Required: the first pulse has no effect; the second causes `resend_l` on the next edge with no PWRUP delay.
- **Coincident events:** `fin_l` rises in the exact timeout cycle of HIGH_L. Required: goes to PULSE_R; `retries` unchanged.
- **Reset mid-sequence:** `rst_n` asserted while `resend_r` is high. Required: `resend_r`=0 immediately (asynchronous) and all outputs at reset values; after release, the full PWRUP delay elapses before `resend_l`.

Source files
------------

// File: rtl/stereocam_pkg.sv
// rtl/stereocam_pkg.sv - shared types and 50 MHz timing defaults for the stereo camera configuration path
package stereocam_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    IDLE,
    PULSE_L,
    LOW_L,
    HIGH_L,
    PULSE_R,
    LOW_R,
    HIGH_R,
    DONE,
    ERROR
  } cfg_state_t;

  localparam logic CAM_LEFT  = 1'b0;
  localparam logic CAM_RIGHT = 1'b1;

  localparam int DEF_PWRUP_CYCLES   = 5_000_000;
  localparam int DEF_RESEND_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 2_500_000;
  localparam int DEF_MAX_RETRY      = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter shared by all sequencer states
module cycle_timer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Loading N makes expired true in the N-th cycle after the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/stereo_config_sequencer.sv
// rtl/stereo_config_sequencer.sv - serialises left/right OV7670 SCCB configuration with timeouts and retry
module stereo_config_sequencer
  import stereocam_pkg::*;
#(
  parameter int PWRUP_CYCLES   = DEF_PWRUP_CYCLES,
  parameter int RESEND_CYCLES  = DEF_RESEND_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       fin_l,
  input  logic       fin_r,
  output logic       resend_l,
  output logic       resend_r,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       err_cam,
  output logic [1:0] retries
);

  // One extra count of headroom so the largest load value itself fits.
  localparam int TMAX = max3(PWRUP_CYCLES, RESEND_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;
  localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);

  cfg_state_t state, next_state;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expired;

  logic [RW-1:0] retry_cnt, retry_cnt_d;
  logic          can_retry;
  logic          resend_l_d, resend_r_d, busy_d, done_d, error_d, err_cam_d;
  logic [1:0]    retries_d;

  cycle_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (TW'(PWRUP_CYCLES))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  assign can_retry = (retry_cnt < MAX_RETRY_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PWRUP;
    end else begin
      state <= next_state;
    end
  end

  // A fin transition is tested before the timeout so it wins a same-cycle tie.
  always_comb begin
    next_state = state;
    case (state)
      PWRUP:             if (tmr_expired) next_state = PULSE_L;
      IDLE, DONE, ERROR: if (start) next_state = PULSE_L;
      PULSE_L:           if (tmr_expired) next_state = LOW_L;
      LOW_L: begin
        if (!fin_l)           next_state = HIGH_L;
        else if (tmr_expired) next_state = can_retry ? PULSE_L : ERROR;
      end
      HIGH_L: begin
        if (fin_l)            next_state = PULSE_R;
        else if (tmr_expired) next_state = can_retry ? PULSE_L : ERROR;
      end
      PULSE_R:           if (tmr_expired) next_state = LOW_R;
      LOW_R: begin
        if (!fin_r)           next_state = HIGH_R;
        else if (tmr_expired) next_state = can_retry ? PULSE_R : ERROR;
      end
      HIGH_R: begin
        if (fin_r)            next_state = DONE;
        else if (tmr_expired) next_state = can_retry ? PULSE_R : ERROR;
      end
      default:           next_state = PWRUP;
    endcase
  end

  always_comb begin
    tmr_load   = (next_state != state);
    tmr_value  = TW'(TIMEOUT_CYCLES);
    resend_l_d = (next_state == PULSE_L);
    resend_r_d = (next_state == PULSE_R);
    busy_d     = !(next_state inside {IDLE, DONE, ERROR});
    done_d     = (next_state == DONE);
    error_d    = (next_state == ERROR);
    err_cam_d  = 1'b0;
    retry_cnt_d = retry_cnt;

    case (next_state)
      PULSE_L, PULSE_R: tmr_value = TW'(RESEND_CYCLES);
      PWRUP:            tmr_value = TW'(PWRUP_CYCLES);
      default:          tmr_value = TW'(TIMEOUT_CYCLES);
    endcase

    if (next_state == ERROR) begin
      if (state == ERROR)
        err_cam_d = err_cam;
      else
        err_cam_d = (state inside {LOW_R, HIGH_R}) ? CAM_RIGHT : CAM_LEFT;
    end

    // A fresh sequence or the hand-over to the right camera restarts the count.
    if ((next_state == PULSE_L && !(state inside {PULSE_L, LOW_L, HIGH_L})) ||
        (next_state == PULSE_R && state == HIGH_L))
      retry_cnt_d = '0;
    else if ((next_state == PULSE_L && state inside {LOW_L, HIGH_L}) ||
             (next_state == PULSE_R && state inside {LOW_R, HIGH_R}))
      retry_cnt_d = retry_cnt + 1'b1;

    retries_d = (retry_cnt_d > RW'(3)) ? 2'd3 : retry_cnt_d[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resend_l  <= 1'b0;
      resend_r  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_cam   <= 1'b0;
      retry_cnt <= '0;
      retries   <= 2'd0;
    end else begin
      resend_l  <= resend_l_d;
      resend_r  <= resend_r_d;
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      err_cam   <= err_cam_d;
      retry_cnt <= retry_cnt_d;
      retries   <= retries_d;
    end
  end

endmodule

// File: tb/tb_stereo_config_sequencer.sv
// tb/tb_stereo_config_sequencer.sv - directed scoreboard bench for stereo_config_sequencer
module tb_stereo_config_sequencer;

  localparam int PW = 10;
  localparam int RS = 2;
  localparam int TO = 20;
  localparam int MR = 2;

  typedef struct {
    int cam;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       fin_l, fin_r;
  logic       resend_l, resend_r, busy, done, error, err_cam;
  logic [1:0] retries;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   w_q[$];
  logic both_seen = 1'b0;

  int   l_stuck_until = 0;
  logic r_stuck = 1'b0;
  int   l_rise = 11;
  int   l_n = 0;

  stereo_config_sequencer #(
    .PWRUP_CYCLES   (PW),
    .RESEND_CYCLES  (RS),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fin_l    (fin_l),
    .fin_r    (fin_r),
    .resend_l (resend_l),
    .resend_r (resend_r),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_cam  (err_cam),
    .retries  (retries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: fin drops 3 cycles after a resend rise and rises l_rise/11 cycles after it.
  initial begin
    int   tl, tr;
    logic ml, mr;
    tl = -1000; tr = -1000; ml = 1'b0; mr = 1'b0;
    fin_l = 1'b1; fin_r = 1'b1;
    forever begin
      @(negedge clk);
      if (resend_l && !ml) begin
        l_n++;
        tl = (l_n <= l_stuck_until) ? -1000 : cyc;
      end
      if (resend_r && !mr) tr = cyc;
      if (cyc == tl + 3) fin_l = 1'b0;
      if (cyc == tl + l_rise) fin_l = 1'b1;
      if (cyc == tr + 3) fin_r = 1'b0;
      if (cyc == tr + 11 && !r_stuck) fin_r = 1'b1;
      ml = resend_l;
      mr = resend_r;
    end
  end

  // Monitor: records each resend rise and the width of each completed pulse.
  initial begin
    logic pl, pr;
    int   hl, hr;
    ev_t  e;
    pl = 1'b0; pr = 1'b0; hl = 0; hr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pl = 1'b0; pr = 1'b0; hl = 0; hr = 0;
      end else begin
        if (resend_l && !pl) begin e.cam = 0; e.cyc = cyc; obs_q.push_back(e); end
        if (resend_r && !pr) begin e.cam = 1; e.cyc = cyc; obs_q.push_back(e); end
        if (resend_l) hl++;
        else if (pl) begin w_q.push_back(hl); hl = 0; end
        if (resend_r) hr++;
        else if (pr) begin w_q.push_back(hr); hr = 0; end
        if (resend_l && resend_r) both_seen = 1'b1;
        pl = resend_l;
        pr = resend_r;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int cam, input int c);
    ev_t e;
    e.cam = cam;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic score(input string tag);
    ev_t o, e;
    check({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_pulse_cam"}, o.cam, e.cam);
      check({tag, "_pulse_cycle"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
    while (w_q.size() > 0) check({tag, "_pulse_width"}, w_q.pop_front(), RS);
  endtask

  task automatic wait_end(input string tag, input int limit);
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_in_budget"}, (n < limit), 1);
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resend_l"}, resend_l, 0);
    check({tag, "_resend_r"}, resend_r, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_cam"}, err_cam, 0);
    check({tag, "_retries"}, retries, 0);
  endtask

  initial begin
    int s;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Nominal power-up
    rst_n = 1'b1;
    s = cyc;
    expect_pulse(0, s + PW);
    expect_pulse(1, s + PW + 12);
    check("pwrup_busy_before_edge", busy, 0);
    @(negedge clk);
    check("pwrup_busy_first_edge", busy, 1);
    goto(s + PW - 1);
    check("pwrup_no_early_resend", resend_l, 0);
    wait_end("nominal", 200);
    check("nominal_done_cycle", cyc, s + PW + 24);
    check("nominal_done", done, 1);
    check("nominal_busy", busy, 0);
    check("nominal_retries", retries, 0);
    score("nominal");

    // Left retry: first attempt never sees fin_l drop
    l_stuck_until = l_n + 1;
    s = cyc;
    start = 1'b1;
    expect_pulse(0, s + 1);
    expect_pulse(0, s + 1 + RS + TO);
    expect_pulse(1, s + 1 + RS + TO + 12);
    @(negedge clk);
    start = 1'b0;
    check("lretry_busy_on_start", busy, 1);
    check("lretry_done_cleared", done, 0);
    goto(s + 24);
    check("lretry_retries_2nd", retries, 1);
    goto(s + 34);
    check("lretry_retries_before_r", retries, 1);
    goto(s + 35);
    check("lretry_retries_cleared", retries, 0);
    wait_end("lretry", 200);
    check("lretry_done_cycle", cyc, s + 47);
    check("lretry_done", done, 1);
    score("lretry");

    // Right failure: fin_r stuck low after the first resend_r
    r_stuck = 1'b1;
    s = cyc;
    start = 1'b1;
    expect_pulse(0, s + 1);
    expect_pulse(1, s + 13);
    expect_pulse(1, s + 37);
    expect_pulse(1, s + 60);
    @(negedge clk);
    start = 1'b0;
    goto(s + 38);
    check("rfail_retries_mid", retries, 1);
    wait_end("rfail", 300);
    check("rfail_error_cycle", cyc, s + 83);
    check("rfail_error", error, 1);
    check("rfail_err_cam", err_cam, 1);
    check("rfail_retries", retries, MR);
    check("rfail_busy", busy, 0);
    check("rfail_done", done, 0);
    score("rfail");
    r_stuck = 1'b0;

    // Start from ERROR, plus an ignored start during HIGH_L
    s = cyc;
    start = 1'b1;
    expect_pulse(0, s + 1);
    expect_pulse(1, s + 13);
    @(negedge clk);
    start = 1'b0;
    check("restart_error_cleared", error, 0);
    check("restart_retries_cleared", retries, 0);
    goto(s + 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("ignored_start", 200);
    check("ignored_start_done_cycle", cyc, s + 25);
    check("ignored_start_done", done, 1);
    check("ignored_start_error", error, 0);
    score("ignored_start");

    // Start in DONE with fin_l rising in the HIGH_L timeout cycle
    l_rise = 3 + 20;
    s = cyc;
    start = 1'b1;
    expect_pulse(0, s + 1);
    expect_pulse(1, s + 25);
    @(negedge clk);
    start = 1'b0;
    check("done_start_resend_l", resend_l, 1);
    check("done_start_busy", busy, 1);
    check("done_start_done_cleared", done, 0);
    goto(s + 24);
    check("coincide_pre_resend_r", resend_r, 0);
    goto(s + 25);
    check("coincide_resend_r", resend_r, 1);
    check("coincide_no_resend_l", resend_l, 0);
    check("coincide_retries", retries, 0);
    wait_end("coincide", 200);
    check("coincide_done_cycle", cyc, s + 37);
    score("coincide");
    l_rise = 11;

    // Reset asserted while resend_r is high
    s = cyc;
    start = 1'b1;
    expect_pulse(0, s + 1);
    expect_pulse(1, s + 13);
    @(negedge clk);
    start = 1'b0;
    goto(s + 13);
    check("midrst_resend_r_high", resend_r, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    score("midrst_pre");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s = cyc;
    expect_pulse(0, s + PW);
    expect_pulse(1, s + PW + 12);
    wait_end("midrst_post", 200);
    check("midrst_done_cycle", cyc, s + PW + 24);
    check("midrst_done", done, 1);
    score("midrst_post");

    check("resend_exclusive", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1);
  end

endmodule
